// File: rtl/mips_seq_alu.sv
// ---------------------------------------------------------------------------
// mips_seq_alu -- execute-stage ALU with iterative multiply/divide
//
// Single-cycle ops (and/or/add/sub/slt/shifts/xor/nor) register their result
// at the accepting edge and pulse done in the following cycle. mul/div run a
// shift-add / restoring-subtract loop for WIDTH cycles while busy stalls the
// pipeline.
//
// Optional build macro:
//   ALU_SIGNED_MULDIV_EN - mul/div take two's-complement operands: the loop
//                          runs on magnitudes and one extra fix-up cycle
//                          applies the signs (latency WIDTH+2 instead of
//                          WIDTH+1).
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 8)
//   CNT_W  iteration counter width (>= clog2(WIDTH)+1)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        issue request, accepted only while busy=0
//   alu_ctrl     4-bit op code from the ALU control decoder
//   a, b         operands rs / rt
//   shamt        shift amount
//   busy         high while mul/div iterates (pipeline stall)
//   done         one-cycle completion pulse
//   result       main result (lo / quotient)
//   hi           mul upper half / div remainder, 0 otherwise
//   zero         result == 0
//   overflow     signed overflow of add/sub
//   div_by_zero  div issued with b == 0
//   invalid      unsupported op code (3, 13-15)
// ---------------------------------------------------------------------------
module mips_seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             invalid
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_XOR = 4'd10;
    localparam logic [3:0] OP_NOR = 4'd11;
    localparam logic [3:0] OP_SRA = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,   // sign fix-up, reachable only in the signed mul/div build
        S_DONE
    } state_e;

    state_e state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             is_mul;      // iteration in flight is a mul (else div)
    logic [WIDTH-1:0] acc_hi;      // mul: running upper half / div: remainder
    logic [WIDTH-1:0] acc_lo;      // mul: multiplier -> low product / div: dividend -> quotient
    logic [WIDTH-1:0] opnd;        // mul: multiplicand / div: divisor

    logic accept, is_iter, last;

    assign accept  = start && (state == S_IDLE || state == S_DONE);
    assign is_iter = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_DIV && b != '0);
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    // ---------------- single-cycle ops ----------------
    logic [WIDTH-1:0] sum_ab, diff_ab;
    logic [WIDTH-1:0] s_res, s_hi;
    logic             s_ovf, s_dbz, s_inv;

    assign sum_ab  = a + b;
    assign diff_ab = a - b;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        s_res = '0;
        s_hi  = '0;
        s_ovf = 1'b0;
        s_dbz = 1'b0;
        s_inv = 1'b0;
        case (alu_ctrl)
            OP_AND: s_res = a & b;
            OP_OR:  s_res = a | b;
            OP_ADD: begin
                s_res = sum_ab;
                s_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_res = diff_ab;
                s_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: s_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: s_res = b << shamt;
            OP_SRL: s_res = b >> shamt;
            OP_SRA: s_res = $signed(b) >>> shamt;
            OP_XOR: s_res = a ^ b;
            OP_NOR: s_res = ~(a | b);
            // Only the b==0 case of div reaches this path; it skips iteration.
            OP_DIV: begin
                s_res = '1;
                s_hi  = a;
                s_dbz = 1'b1;
            end
            OP_MUL: s_res = '0;   // always iterative, never registered from here
            default: s_inv = 1'b1;
        endcase
    end

    // ---------------- operand conditioning ----------------
    logic [WIDTH-1:0] mag_a, mag_b;
`ifdef ALU_SIGNED_MULDIV_EN
    logic neg_q;   // product / quotient must be negated
    logic neg_r;   // remainder must be negated (follows dividend sign)
    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;
`else
    assign mag_a = a;
    assign mag_b = b;
`endif

    // ---------------- one mul/div iteration ----------------
    logic [WIDTH:0]   mul_sum, rem_sh;
    logic [WIDTH-1:0] rem_sub, it_hi, it_lo;
    logic             rem_ge;

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole pair right (carry in).
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        // Restoring divide: shift the next dividend bit into the remainder.
        // rem_sh < 2*divisor, so a successful subtract always fits WIDTH bits.
        rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, opnd});
        rem_sub = rem_sh[WIDTH-1:0] - opnd;
        if (is_mul) begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            it_hi = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            it_lo = {acc_lo[WIDTH-2:0], rem_ge};
        end
    end

    // ---------------- final mul/div values ----------------
    logic [WIDTH-1:0] fin_hi, fin_lo;
    logic             fin_wr;

`ifdef ALU_SIGNED_MULDIV_EN
    logic [2*WIDTH-1:0] prod_fix;
    always_comb begin
        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        if (is_mul) begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end else begin
            fin_hi = neg_r ? -acc_hi : acc_hi;
            fin_lo = neg_q ? -acc_lo : acc_lo;
        end
    end
    assign fin_wr = (state == S_FIX);
`else
    assign fin_hi = it_hi;
    assign fin_lo = it_lo;
    assign fin_wr = (state == S_RUN) && last;
`endif

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff sees pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept)                state_nxt = is_iter ? S_RUN : S_DONE;
                else if (state == S_DONE)  state_nxt = S_IDLE;
            end
            S_RUN: begin
`ifdef ALU_SIGNED_MULDIV_EN
                if (last) state_nxt = S_FIX;
`else
                if (last) state_nxt = S_DONE;
`endif
            end
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state == S_RUN) || (state == S_FIX);
        done = (state == S_DONE);
    end

    // ---------------- datapath and result registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            is_mul      <= 1'b0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            opnd        <= '0;
            result      <= '0;
            hi          <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else if (accept) begin
            cnt    <= '0;
            is_mul <= (alu_ctrl == OP_MUL);
            if (is_iter) begin
                // Outputs keep their previous values until the loop finishes.
                acc_hi <= '0;
                acc_lo <= (alu_ctrl == OP_MUL) ? mag_b : mag_a;
                opnd   <= (alu_ctrl == OP_MUL) ? mag_a : mag_b;
`ifdef ALU_SIGNED_MULDIV_EN
                neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_r  <= a[WIDTH-1];
`endif
            end else begin
                result      <= s_res;
                hi          <= s_hi;
                zero        <= (s_res == '0);
                overflow    <= s_ovf;
                div_by_zero <= s_dbz;
                invalid     <= s_inv;
            end
        end else begin
            if (state == S_RUN) begin
                cnt    <= cnt + CNT_W'(1);
                acc_hi <= it_hi;
                acc_lo <= it_lo;
            end
            if (fin_wr) begin
                result      <= fin_lo;
                hi          <= fin_hi;
                zero        <= (fin_lo == '0);
                overflow    <= 1'b0;
                div_by_zero <= 1'b0;
                invalid     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_mips_seq_alu -- directed self-checking bench for mips_seq_alu (WIDTH=32)
// Expected values are hand-computed constants. Honours ALU_SIGNED_MULDIV_EN
// for mul/div latency and the signed mul/div vectors.
// ---------------------------------------------------------------------------
module tb_mips_seq_alu;

    localparam int W = 32;
`ifdef ALU_SIGNED_MULDIV_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] a, b;
    logic [4:0]   shamt;
    logic         busy, done, zero, overflow, div_by_zero, invalid;
    logic [W-1:0] result, hi;

    int n_checks = 0;
    int n_fail   = 0;

    mips_seq_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .a           (a),
        .b           (b),
        .shamt       (shamt),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .hi          (hi),
        .zero        (zero),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op with start=1 for one edge; returns in cycle T+1.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic [4:0] sh);
        alu_ctrl = op;
        a        = aa;
        b        = bb;
        shamt    = sh;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_res"},   result, 0);
        check({tag, "_hi"},    hi, 0);
        check({tag, "_zero"},  zero, 0);
        check({tag, "_ovf"},   overflow, 0);
        check({tag, "_dbz"},   div_by_zero, 0);
        check({tag, "_inv"},   invalid, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_ctrl = '0; a = '0; b = '0; shamt = '0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // add with signed overflow
        issue(4'd2, 32'h7FFF_FFFF, 32'h1, 5'd0);
        check("add_done", done, 1);
        check("add_res",  result, 64'h8000_0000);
        check("add_ovf",  overflow, 1);
        check("add_zero", zero, 0);
        check("add_hi",   hi, 0);
        step();
        check("add_done_drop", done, 0);
        check("add_hold",      result, 64'h8000_0000);

        // sub to zero
        issue(4'd6, 32'd5, 32'd5, 5'd0);
        check("sub_res",  result, 0);
        check("sub_zero", zero, 1);
        check("sub_ovf",  overflow, 0);

        // back-to-back single-cycle ops; done stays high
        issue(4'd12, 32'h0, 32'hF000_0000, 5'd4);
        check("sra_res", result, 64'hFF00_0000);
        issue(4'd8, 32'h0, 32'h1, 5'd31);
        check("sll_res",  result, 64'h8000_0000);
        check("sll_done", done, 1);
        issue(4'd7, 32'hFFFF_FFFF, 32'h1, 5'd0);
        check("slt_res", result, 1);
        issue(4'd9, 32'h0, 32'h8000_0000, 5'd31);
        check("srl_res", result, 1);
        issue(4'd10, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
        check("xor_res", result, 64'h0FF0);
        issue(4'd11, 32'h0, 32'h0, 5'd0);
        check("nor_res", result, 64'hFFFF_FFFF);
        issue(4'd0, 32'hC, 32'hA, 5'd0);
        check("and_res", result, 8);
        issue(4'd1, 32'hC, 32'hA, 5'd0);
        check("or_res",  result, 64'hE);
        check("or_ovf",  overflow, 0);
        step();

        // mul 0x10000 * 0x10000 with an ignored start mid-run
        issue(4'd5, 32'h0001_0000, 32'h0001_0000, 5'd0);
        for (int k = 1; k < LAT; k++) begin
            check($sformatf("mul_busy_%0d", k), busy, 1);
            check($sformatf("mul_ndone_%0d", k), done, 0);
            if (k == 5) begin
                alu_ctrl = 4'd2; a = 32'd1; b = 32'd1; start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        check("mul_done", done, 1);
        check("mul_busy_end", busy, 0);
        check("mul_res",  result, 0);
        check("mul_hi",   hi, 1);
        check("mul_zero", zero, 1);
        step();

        // div 100 / 7
        issue(4'd4, 32'd100, 32'd7, 5'd0);
        for (int k = 1; k < LAT; k++) begin
            check($sformatf("div_busy_%0d", k), busy, 1);
            step();
        end
        check("div_done", done, 1);
        check("div_res",  result, 14);
        check("div_hi",   hi, 2);
        check("div_zero", zero, 0);
        check("div_dbz",  div_by_zero, 0);
        step();

        // div by zero completes immediately
        issue(4'd4, 32'd9, 32'd0, 5'd0);
        check("dbz_done", done, 1);
        check("dbz_busy", busy, 0);
        check("dbz_res",  result, 64'hFFFF_FFFF);
        check("dbz_hi",   hi, 9);
        check("dbz_flag", div_by_zero, 1);
        step();

        // all-ones multiply (unsigned boundary / signed -1 * -1)
        issue(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        for (int k = 1; k < LAT; k++) step();
        check("mulff_done", done, 1);
`ifdef ALU_SIGNED_MULDIV_EN
        check("mulff_res", result, 1);
        check("mulff_hi",  hi, 0);
        step();
        issue(4'd4, -32'sd7, 32'd2, 5'd0);
        for (int k = 1; k < LAT; k++) step();
        check("sdiv_done", done, 1);
        check("sdiv_res",  result, 64'hFFFF_FFFD);
        check("sdiv_hi",   hi, 64'hFFFF_FFFF);
        step();
        issue(4'd5, -32'sd3, 32'd4, 5'd0);
        for (int k = 1; k < LAT; k++) step();
        check("smul_done", done, 1);
        check("smul_res",  result, 64'hFFFF_FFF4);
        check("smul_hi",   hi, 64'hFFFF_FFFF);
`else
        check("mulff_res", result, 1);
        check("mulff_hi",  hi, 64'hFFFF_FFFE);
`endif
        step();

        // invalid codes back-to-back
        issue(4'd3, 32'h55, 32'h66, 5'd0);
        check("inv3_done", done, 1);
        check("inv3_flag", invalid, 1);
        check("inv3_res",  result, 0);
        check("inv3_zero", zero, 1);
        issue(4'd14, 32'h55, 32'h66, 5'd0);
        check("inv14_done", done, 1);
        check("inv14_flag", invalid, 1);
        check("inv14_hi",   hi, 0);

        // reset in the middle of a div
        issue(4'd4, 32'd100, 32'd7, 5'd0);
        for (int k = 1; k < 10; k++) step();
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        step();
        check_all_zero("midrst");
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            step();
            check($sformatf("midrst_nodone_%0d", k), done, 0);
        end

        // recovery
        issue(4'd2, 32'd2, 32'd3, 5'd0);
        check("rec_done", done, 1);
        check("rec_res",  result, 5);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_seq_alu.md
Name: mips_seq_alu

Overview:
- Execute-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder.
- Single-cycle ops (and/or/add/sub/slt/shifts/xor/nor) return a registered result one cycle after start.
- mul and div run on an iterative shift-add / restoring-subtract datapath lasting WIDTH cycles.
- busy is driven to the pipeline hazard unit as a stall.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two, at least 8.
- CNT_W, 6: iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  issue request; accepted only when busy=0
- alu_ctrl  in  4  op code: 0 and, 1 or, 2 add, 4 div, 5 mul, 6 sub, 7 slt, 8 sll, 9 srl, 10 xor, 11 nor, 12 sra; 3 and 13-15 invalid
- a  in  WIDTH  operand rs
- b  in  WIDTH  operand rt
- shamt  in  5  shift amount
- busy  out  1  high while a mul/div is iterating
- done  out  1  one-cycle pulse; result/hi/flags valid that cycle and held until the next accepted start
- result  out  WIDTH  main result (lo / quotient)
- hi  out  WIDTH  mul upper half / div remainder; 0 for other ops
- zero  out  1  result==0
- overflow  out  1  signed overflow, add/sub only
- div_by_zero  out  1  div issued with b==0
- invalid  out  1  code 3 or 13-15

Behaviour:
- Reset, sampled at a clk edge with rst_n=0: state=IDLE, counter=0, all outputs 0. This applies mid-operation too; the partial mul/div is discarded and no done is produced.
- States:
  - IDLE: no result pending.
  - RUN: mul/div iterating.
  - DONE: done=1 for exactly one cycle.
- start is accepted in IDLE or DONE; busy=(state==RUN); start while busy is ignored with no queueing.
- Simple op accepted at edge T: result, hi=0 and flags are registered at T; DONE follows; done=1 in cycle T+1. Back-to-back issue gives one op per cycle, with done staying high.
- mul/div accepted at T: operands are latched and counter=0; state=RUN for cycles T+1..T+WIDTH, one iteration per cycle; DONE in cycle T+WIDTH+1, so latency is WIDTH+1.
- Operands a/b/alu_ctrl may change freely once start is accepted.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - overflow = signed overflow for add (2) and sub (6); 0 for every other code.
  - slt is a signed compare, result 1 or 0.
  - sll/srl/sra shift b by shamt; sra sign-fills.
  - mul: {hi,result} = full 2*WIDTH product.
  - div: result = quotient, hi = remainder.
- div with b==0: skips iteration and goes to DONE at T+1; result = all ones, hi = a, div_by_zero=1.
- Invalid code: done at T+1 with result=0, hi=0, invalid=1, zero=1.
- zero is computed on result only, for every op.
- Flags not relevant to the issued op are 0.
- After done, outputs hold until the next accepted start registers new values.

Optional Feature:
- Macro: ALU_SIGNED_MULDIV_EN
- Defined:
  - mul/div operate on two's-complement operands via magnitude iteration plus sign fix-up.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - One extra fix-up cycle is added, so mul/div latency = WIDTH+2 with busy held through the fix-up.
- Undefined: mul/div are unsigned with latency WIDTH+1 and no fix-up logic.
- Single-cycle ops are unaffected either way.

Test Plan:
- Reset, then add a=0x7FFFFFFF b=1 -> done at T+1, result=0x80000000, overflow=1, zero=0; sub a=5 b=5 -> result=0, zero=1, overflow=0.
- sra b=0xF0000000 shamt=4 -> result=0xFF000000; sll b=1 shamt=31 -> 0x80000000; slt a=0xFFFFFFFF b=1 -> result=1.
- mul a=0x10000 b=0x10000 -> busy high cycles T+1..T+32, done at T+33, result=0, hi=1. A start at T+5 is ignored and the result is unchanged.
- div a=100 b=7 -> result=14, hi=2, done at T+33; div a=9 b=0 -> done at T+1, result=0xFFFFFFFF, hi=9, div_by_zero=1.
- alu_ctrl=3, then alu_ctrl=14 issued back-to-back -> invalid=1, result=0, done high two consecutive cycles. rst_n=0 at T+10 of a div -> next cycle busy=0, done=0, all outputs 0.
- With ALU_SIGNED_MULDIV_EN: div a=-7 b=2 -> result=-3, hi=-1, done at T+34; mul a=-3 b=4 -> result=0xFFFFFFF4, hi=0xFFFFFFFF.
